// File: rtl/regdecr_valrdy.sv
// Registered decrementer with val/rdy handshakes on both sides.
// Each accepted operand has a constant step subtracted and waits in a 2-entry elastic buffer.
module regdecr_valrdy #(
    parameter int unsigned p_nbits = 8,
    parameter int unsigned p_step  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               out_uflow,
    output logic [p_nbits-1:0] count
);

    localparam logic [p_nbits-1:0] STEP  = p_nbits'(p_step);
    localparam logic [p_nbits-1:0] INC_1 = p_nbits'(1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [p_nbits-1:0] head_msg_q, head_msg_d;
    logic               head_uflow_q, head_uflow_d;
    logic [p_nbits-1:0] tail_msg_q, tail_msg_d;
    logic               tail_uflow_q, tail_uflow_d;
    logic [p_nbits-1:0] count_q, count_d;

    logic               enq;
    logic               deq;
    logic [p_nbits-1:0] new_msg;
    logic               new_uflow;

    // Result is {borrow, difference}; the borrow flags a wrapped subtraction.
    function automatic logic [p_nbits:0] decr(input logic [p_nbits-1:0] a);
        return {(a < STEP), a - STEP};
    endfunction

    assign in_rdy    = (state_q != ST_TWO);
    assign out_val   = (state_q != ST_EMPTY);
    assign out_msg   = head_msg_q;
    assign out_uflow = head_uflow_q;
    assign count     = count_q;

    assign enq = in_val & in_rdy;
    assign deq = out_val & out_rdy;
    assign {new_uflow, new_msg} = decr(in_msg);

    always_comb begin
        state_d      = state_q;
        head_msg_d   = head_msg_q;
        head_uflow_d = head_uflow_q;
        tail_msg_d   = tail_msg_q;
        tail_uflow_d = tail_uflow_q;
        count_d      = count_q;

        case (state_q)
            ST_EMPTY: begin
                if (enq) begin
                    state_d      = ST_ONE;
                    head_msg_d   = new_msg;
                    head_uflow_d = new_uflow;
                end
            end
            ST_ONE: begin
                case ({enq, deq})
                    2'b10: begin
                        state_d      = ST_TWO;
                        tail_msg_d   = new_msg;
                        tail_uflow_d = new_uflow;
                    end
                    2'b01: begin
                        state_d = ST_EMPTY;
                    end
                    2'b11: begin
                        // Old head leaves this cycle, so the newcomer takes its slot.
                        head_msg_d   = new_msg;
                        head_uflow_d = new_uflow;
                    end
                    default: begin
                        state_d = ST_ONE;
                    end
                endcase
            end
            ST_TWO: begin
                if (deq) begin
                    state_d      = ST_ONE;
                    head_msg_d   = tail_msg_q;
                    head_uflow_d = tail_uflow_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (deq) begin
            count_d = count_q + INC_1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            head_msg_q   <= '0;
            head_uflow_q <= 1'b0;
            tail_msg_q   <= '0;
            tail_uflow_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            head_msg_q   <= head_msg_d;
            head_uflow_q <= head_uflow_d;
            tail_msg_q   <= tail_msg_d;
            tail_uflow_q <= tail_uflow_d;
            count_q      <= count_d;
        end
    end

`ifndef SYNTHESIS
    function automatic string line_trace();
        string occ;
        case (state_q)
            ST_EMPTY: occ = "0";
            ST_ONE:   occ = "1";
            ST_TWO:   occ = "2";
            default:  occ = "?";
        endcase
        return $sformatf("%s%s%h (%s) %s%s%h",
                         in_val ? "V" : ".", in_rdy ? "R" : ".", in_msg, occ,
                         out_val ? "V" : ".", out_rdy ? "R" : ".", out_msg);
    endfunction

    a_out_stable: assert property (@(posedge clk) disable iff (!reset)
        (out_val && !out_rdy) |=> (out_val && $stable(out_msg) && $stable(out_uflow)));

    a_no_x: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({in_rdy, out_val, out_msg, out_uflow, count}));
`endif

endmodule

// File: tb/tb_regdecr_valrdy.sv
// Bench for regdecr_valrdy: directed traffic on a step-1 instance, random stress on a step-3 instance.
module tb_regdecr_valrdy;

    logic clk = 1'b0;
    logic reset;
    logic probe = 1'b0;

    logic [1:0] in_val;
    logic [1:0] out_rdy;
    logic [7:0] in_msg [2];
    wire  [1:0] in_rdy_w;
    wire  [1:0] out_val_w;
    wire  [1:0] out_uflow_w;
    wire  [7:0] out_msg_w [2];
    wire  [7:0] count_w [2];

    logic [8:0] exp_q [2][$];
    logic [8:0] last_out [2];
    int         ndeq [2];

    int errors = 0;
    int checks = 0;
    int timeouts = 0;
    int timeouts_seen = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        regdecr_valrdy #(.p_nbits(8), .p_step(g == 0 ? 1 : 3)) dut (
            .clk      (clk),
            .reset    (reset),
            .in_val   (in_val[g]),
            .in_rdy   (in_rdy_w[g]),
            .in_msg   (in_msg[g]),
            .out_val  (out_val_w[g]),
            .out_rdy  (out_rdy[g]),
            .out_msg  (out_msg_w[g]),
            .out_uflow(out_uflow_w[g]),
            .count    (count_w[g])
        );
    end

    function automatic int step_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input int g);
        chk($sformatf("rst_out_val%0d", g), 32'(out_val_w[g]), 32'd0);
        chk($sformatf("rst_in_rdy%0d", g), 32'(in_rdy_w[g]), 32'd1);
        chk($sformatf("rst_out_msg%0d", g), 32'(out_msg_w[g]), 32'd0);
        chk($sformatf("rst_uflow%0d", g), 32'(out_uflow_w[g]), 32'd0);
        chk($sformatf("rst_count%0d", g), 32'(count_w[g]), 32'd0);
    endtask

    // Monitor: the queue holds the results the block should currently be buffering.
    always @(negedge clk or posedge probe) begin
        if (probe) begin
            for (int g = 0; g < 2; g++) chk_reset_vals(g);
        end else begin
            if (timeouts != timeouts_seen) begin
                checks++;
                errors++;
                $display("FAIL timeout: got %0d expired waits expected %0d", timeouts, timeouts_seen);
                timeouts_seen = timeouts;
            end
            for (int g = 0; g < 2; g++) begin
                if (!reset) begin
                    chk_reset_vals(g);
                    exp_q[g].delete();
                    last_out[g] = 9'd0;
                    ndeq[g] = 0;
                end else begin
                    int sz;
                    sz = exp_q[g].size();
                    chk($sformatf("in_rdy%0d", g), 32'(in_rdy_w[g]), 32'(sz < 2));
                    chk($sformatf("out_val%0d", g), 32'(out_val_w[g]), 32'(sz > 0));
                    if (sz > 0)
                        chk($sformatf("head%0d", g), 32'({out_uflow_w[g], out_msg_w[g]}), 32'(exp_q[g][0]));
                    else
                        chk($sformatf("hold%0d", g), 32'({out_uflow_w[g], out_msg_w[g]}), 32'(last_out[g]));
                    chk($sformatf("count%0d", g), 32'(count_w[g]), 32'(ndeq[g] % 256));
                    if (out_val_w[g] && out_rdy[g] && sz > 0) begin
                        last_out[g] = exp_q[g].pop_front();
                        ndeq[g]++;
                    end
                    if (in_val[g] && in_rdy_w[g]) begin
                        int d;
                        logic uf;
                        d  = int'(in_msg[g]) - step_of(g);
                        uf = (int'(in_msg[g]) < step_of(g));
                        if (d < 0) d += 256;
                        exp_q[g].push_back({uf, d[7:0]});
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input logic [7:0] m, input int budget);
        logic got;
        got = 1'b0;
        in_val[g] = 1'b1;
        in_msg[g] = m;
        for (int k = 0; k < budget && !got; k++) begin
            got = in_rdy_w[g];
            cyc();
        end
        in_val[g] = 1'b0;
        if (!got) timeouts++;
    endtask

    task automatic drain(input int g);
        int k;
        k = 0;
        out_rdy[g] = 1'b1;
        while (exp_q[g].size() != 0 && k < 100) begin
            cyc();
            k++;
        end
        if (exp_q[g].size() != 0) timeouts++;
        cyc();
    endtask

    function automatic logic [7:0] pick();
        if ($urandom % 8 == 0) return 8'($urandom % 4);
        return 8'($urandom % 256);
    endfunction

    initial begin
        int n;
        int budget;
        logic pending;
        logic acc;
        reset = 1'b0;
        in_val = 2'b00;
        out_rdy = 2'b00;
        in_msg[0] = 8'h00;
        in_msg[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Basic path and wrap/underflow cases
        out_rdy[0] = 1'b1;
        send(0, 8'h05, 4);
        cyc(); cyc();
        send(0, 8'h00, 4);
        cyc();
        send(0, 8'h01, 4);
        cyc(); cyc();

        // Backpressure: two accepted, third stalls while head is held
        out_rdy[0] = 1'b0;
        send(0, 8'h10, 4);
        send(0, 8'h20, 4);
        in_val[0] = 1'b1;
        in_msg[0] = 8'h30;
        repeat (3) cyc();
        out_rdy[0] = 1'b1;
        send(0, 8'h30, 8);
        drain(0);

        // Full throughput run
        for (int i = 1; i <= 10; i++) send(0, 8'(i), 4);
        drain(0);

        // Asynchronous reset while both entries are occupied
        out_rdy[0] = 1'b0;
        send(0, 8'h50, 4);
        send(0, 8'h60, 4);
        #1 reset = 1'b0;
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        cyc();
        reset = 1'b1;
        out_rdy[0] = 1'b1;
        send(0, 8'h42, 4);
        drain(0);

        // Random stress on the step-3 instance
        n = 0;
        budget = 0;
        pending = 1'b0;
        while (n < 200 && budget < 5000) begin
            out_rdy[1] = (($urandom % 4) != 0);
            if (!pending && ($urandom % 10) < 7) begin
                in_msg[1] = pick();
                in_val[1] = 1'b1;
                pending = 1'b1;
            end
            acc = in_val[1] & in_rdy_w[1];
            cyc();
            budget++;
            if (acc) begin
                n++;
                pending = 1'b0;
                in_val[1] = 1'b0;
            end
        end
        if (n < 200) timeouts++;
        drain(1);

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regdecr_valrdy.md
Name: regdecr_valrdy

Overview:
- Registered decrementer with latency-insensitive val/rdy ports on both sides; the counterpart of the registered incrementer.
- Accepts a message, subtracts a constant step, holds the result in a 2-entry elastic buffer, and presents it downstream.
- Sits between val/rdy producers and consumers in the tutorial datapath, where it absorbs one cycle of downstream backpressure without dropping messages.

Parameters:
- p_nbits, 8, width of message and result.
- p_step, 1, constant subtracted from each message; must satisfy 0 < p_step < 2^p_nbits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; asserted at 0, clears state immediately.
- in_val  input  1  upstream message valid.
- in_rdy  output  1  block can accept a message this cycle.
- in_msg  input  p_nbits  operand.
- out_val  output  1  result available.
- out_rdy  input  1  downstream accepts result this cycle.
- out_msg  output  p_nbits  in_msg minus p_step, modulo 2^p_nbits.
- out_uflow  output  1  set for a result whose operand was less than p_step (the subtraction wrapped).
- count  output  p_nbits  number of results delivered since reset, wraps at 2^p_nbits.

Behaviour:
- Transfer rules:
  - Input transfer ("enq") = in_val & in_rdy.
  - Output transfer ("deq") = out_val & out_rdy.
  - Both sampled at posedge clk.
- Arithmetic is done at enqueue:
  - Stored result = (in_msg - p_step) truncated to p_nbits.
  - Stored uflow = (in_msg < p_step), unsigned compare.
- Storage: two entries, head and tail, each holding a result and its uflow bit.
- State machine, with states EMPTY, ONE and TWO:
  - in_rdy = (state != TWO); purely a function of state, with no combinational path from out_rdy.
  - out_val = (state != EMPTY).
  - out_msg/out_uflow = head entry. When EMPTY they hold their last value; they read 0 after reset.
- Transitions:
  - EMPTY: enq -> ONE, head <= new. No enq -> stay. No bypass: a result is never visible in the same cycle its operand arrives, so minimum latency is 1 cycle.
  - ONE, enq only -> TWO, tail <= new.
  - ONE, deq only -> EMPTY.
  - ONE, enq & deq (simultaneous) -> stay ONE, head <= new. The old head is consumed that cycle.
  - ONE, neither -> stay.
  - TWO: enq is impossible (in_rdy=0).
    - deq -> ONE, head <= tail.
    - No deq -> stay; both entries held stable.
- Ordering: strict FIFO; results leave in arrival order. No message is lost or duplicated under any val/rdy pattern.
- count increments by 1 on each deq and wraps from 2^p_nbits-1 to 0.
- Reset:
  - Values while reset=0 (asynchronous): state=EMPTY, out_val=0, in_rdy=1, out_msg=0, out_uflow=0, count=0.
  - Reset mid-operation discards buffered entries without a deq and without incrementing count.
  - First enq is possible on the first posedge with reset=1.
- Output stability: while out_val=1 and out_rdy=0, out_msg/out_uflow stay constant.
- Combinational outputs depend only on registered state; no X on any output after reset.
- Non-synthesis builds provide a line trace showing in_msg with val/rdy, the buffer occupancy, and out_msg with val/rdy.

Test Plan:
- Basic path (p_nbits=8, p_step=1; send 0x05 with out_rdy=1):
  - out_val=1 with out_msg=0x04 and out_uflow=0 exactly one cycle after the enq.
  - count=1 after the deq.
- Wrap and underflow: send 0x00 -> out_msg=0xFF, out_uflow=1. Send 0x01 -> out_msg=0x00, out_uflow=0.
- Backpressure:
  - Stimulus: out_rdy=0; offer 0x10, 0x20, 0x30 back-to-back.
  - Two are accepted; in_rdy=0 while 0x30 is pending, and out_msg=0x0F stays held.
  - Raise out_rdy -> outputs 0x0F, 0x1F, 0x2F in order; count=3.
- Full throughput: in_val=1 and out_rdy=1 for 10 cycles with 0x01..0x0A -> one result per cycle after the first (0x00..0x09), occupancy stays ONE, count=10.
- Reset mid-operation:
  - Stimulus: TWO entries held; drive reset=0 asynchronously between edges.
  - out_val=0, in_rdy=1 and count=0 immediately, without waiting for a clock edge.
  - After release, send 0x42 -> 0x41.
- Random val/rdy stress, p_step=3, 200 messages, scoreboard -> every output equals (in-3) mod 256 in order, uflow matches in<3, count=200 mod 256 = 0xC8.
